// File: rtl/mprj_io_pkg.sv
// mprj_io_pkg: shared default sizes and the counter-width helper for the mprj_io pad bank
package mprj_io_pkg;
  localparam int MPRJ_IO_PADS          = 38;
  localparam int MPRJ_IO_SYNC_STAGES   = 2;
  localparam int MPRJ_IO_FILTER_CYCLES = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/mprj_io_pad_ctrl.sv
// mprj_io_pad_ctrl: one pad - output hold, input sync (+ deglitch when MPRJ_IO_DEGLITCH_EN), edge flags
module mprj_io_pad_ctrl
  import mprj_io_pkg::*;
#(
  parameter int SYNC_STAGES   = MPRJ_IO_SYNC_STAGES,
  parameter int FILTER_CYCLES = MPRJ_IO_FILTER_CYCLES
) (
  input  logic clock_i,
  input  logic resetb_i,
  input  logic pad_i,
  input  logic io_out_i,
  input  logic oeb_i,
  input  logic inp_dis_i,
  input  logic hold_i,
  input  logic irq_rise_en_i,
  input  logic irq_fall_en_i,
  input  logic irq_clr_i,
  output logic pad_oe_o,
  output logic pad_out_o,
  output logic io_in_o,
  output logic irq_pending_o
);
  logic                   hold_out_q, hold_oeb_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q, pend_q, pend_d;
  logic                   s, io_in, set;

  // hold registers track the live output until hold freezes them
  always_ff @(posedge clock_i or negedge resetb_i)
    if (!resetb_i) begin
      hold_out_q <= 1'b0;
      hold_oeb_q <= 1'b1;
    end else if (!hold_i) begin
      hold_out_q <= io_out_i;
      hold_oeb_q <= oeb_i;
    end

  assign pad_oe_o  = hold_i ? ~hold_oeb_q : ~oeb_i;
  assign pad_out_o = hold_i ? hold_out_q : io_out_i;

  // metastability synchroniser on the gated pad input
  always_ff @(posedge clock_i or negedge resetb_i)
    if (!resetb_i) sync_q <= '0;
    else           sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i & ~inp_dis_i};

  assign s = sync_q[SYNC_STAGES-1];

`ifdef MPRJ_IO_DEGLITCH_EN
  localparam int CW = clog2(FILTER_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          io_in_q;

  // io_in only follows s after it has disagreed for FILTER_CYCLES consecutive clocks
  always_ff @(posedge clock_i or negedge resetb_i)
    if (!resetb_i) begin
      cnt_q   <= '0;
      io_in_q <= 1'b0;
    end else if (s == io_in_q) begin
      cnt_q   <= '0;
    end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
      io_in_q <= s;
      cnt_q   <= '0;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end

  assign io_in = io_in_q;
`else
  assign io_in = s;
`endif

  assign set    = (io_in & ~prev_q & irq_rise_en_i) | (~io_in & prev_q & irq_fall_en_i);
  assign pend_d = set | (pend_q & ~irq_clr_i);

  // edge history and sticky pending flag; a new edge beats a simultaneous clear
  always_ff @(posedge clock_i or negedge resetb_i)
    if (!resetb_i) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= io_in;
      pend_q <= pend_d;
    end

  assign io_in_o       = io_in;
  assign irq_pending_o = pend_q;
endmodule

// File: rtl/mprj_io_bank.sv
// mprj_io_bank: clocked user-GPIO pad bank with hold, sync, edge IRQs (deglitch filter under MPRJ_IO_DEGLITCH_EN)
module mprj_io_bank
  import mprj_io_pkg::*;
#(
  parameter int TOTAL_PADS    = MPRJ_IO_PADS,
  parameter int SYNC_STAGES   = MPRJ_IO_SYNC_STAGES,
  parameter int FILTER_CYCLES = MPRJ_IO_FILTER_CYCLES
) (
  input  logic                  clock,
  input  logic                  resetb,
  inout  wire  [TOTAL_PADS-1:0] io,
  input  logic [TOTAL_PADS-1:0] io_out,
  input  logic [TOTAL_PADS-1:0] oeb,
  input  logic [TOTAL_PADS-1:0] inp_dis,
  input  logic [TOTAL_PADS-1:0] hold,
  input  logic [TOTAL_PADS-1:0] irq_rise_en,
  input  logic [TOTAL_PADS-1:0] irq_fall_en,
  input  logic [TOTAL_PADS-1:0] irq_clr,
  output logic [TOTAL_PADS-1:0] io_in,
  output logic [TOTAL_PADS-1:0] irq_pending,
  output logic                  irq
);
  logic [TOTAL_PADS-1:0] pad_oe, pad_out;

  for (genvar i = 0; i < TOTAL_PADS; i++) begin : g_pad
    mprj_io_pad_ctrl #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_pad (
      .clock_i      (clock),
      .resetb_i     (resetb),
      .pad_i        (io[i]),
      .io_out_i     (io_out[i]),
      .oeb_i        (oeb[i]),
      .inp_dis_i    (inp_dis[i]),
      .hold_i       (hold[i]),
      .irq_rise_en_i(irq_rise_en[i]),
      .irq_fall_en_i(irq_fall_en[i]),
      .irq_clr_i    (irq_clr[i]),
      .pad_oe_o     (pad_oe[i]),
      .pad_out_o    (pad_out[i]),
      .io_in_o      (io_in[i]),
      .irq_pending_o(irq_pending[i])
    );
    assign io[i] = pad_oe[i] ? pad_out[i] : 1'bz;
  end

  assign irq = |irq_pending;
endmodule

// File: tb/tb_mprj_io_bank.sv
// tb_mprj_io_bank: randomized + directed scoreboard bench for mprj_io_bank against a behavioural pad model
module tb_mprj_io_bank;
  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int FILT = 4;

  logic         clock = 1'b0;
  logic         resetb = 1'b0;
  wire  [N-1:0] io;
  logic [N-1:0] io_out, oeb, inp_dis, hold, rise_en, fall_en, clr;
  logic [N-1:0] io_in, pend;
  logic         irq;
  logic [N-1:0] tb_en = '0, tb_val = '0;

  logic [N-1:0] s_io_out = '0, s_oeb = '1, s_inp_dis = '0, s_hold = '0;
  logic [N-1:0] s_rise = '0, s_fall = '0, s_clr = '0, s_ext = '0;

  logic [N-1:0] m_hout, m_hoeb, m_in, m_prev, m_pend;
  logic [N-1:0] m_rawq[$];
  int           m_run[N];

  typedef struct {
    logic [N-1:0] io_in;
    logic [N-1:0] pend;
    logic [N-1:0] io;
    logic         irq;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mprj_io_bank #(.TOTAL_PADS(N), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT)) dut (
    .clock(clock), .resetb(resetb), .io(io), .io_out(io_out), .oeb(oeb), .inp_dis(inp_dis),
    .hold(hold), .irq_rise_en(rise_en), .irq_fall_en(fall_en), .irq_clr(clr),
    .io_in(io_in), .irq_pending(pend), .irq(irq)
  );

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign io[g] = tb_en[g] ? tb_val[g] : 1'bz;
  end

  function automatic logic [N-1:0] m_oe();
    return (hold & ~m_hoeb) | (~hold & ~oeb);
  endfunction

  function automatic logic [N-1:0] m_bus();
    logic [N-1:0] oe, drv;
    oe  = m_oe();
    drv = (hold & m_hout) | (~hold & io_out);
    return (oe & drv) | (~oe & tb_val);
  endfunction

  task automatic model_reset();
    m_hout = '0;
    m_hoeb = '1;
    m_in   = '0;
    m_prev = '0;
    m_pend = '0;
    m_rawq = {};
    repeat (SYNC) m_rawq.push_back('0);
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] raw, s_old, set;
    raw    = m_bus() & ~inp_dis;
    s_old  = m_rawq[SYNC-1];
    set    = (m_in & ~m_prev & rise_en) | (~m_in & m_prev & fall_en);
    m_pend = set | (m_pend & ~clr);
    m_prev = m_in;
    m_hout = (hold & m_hout) | (~hold & io_out);
    m_hoeb = (hold & m_hoeb) | (~hold & oeb);
    m_rawq.push_front(raw);
    void'(m_rawq.pop_back());
`ifdef MPRJ_IO_DEGLITCH_EN
    for (int i = 0; i < N; i++)
      if (s_old[i] == m_in[i]) m_run[i] = 0;
      else if (++m_run[i] == FILT) begin
        m_in[i]  = s_old[i];
        m_run[i] = 0;
      end
`else
    m_in = m_rawq[SYNC-1];
`endif
  endtask

  task automatic apply(input bit push);
    exp_t e;
    io_out  = s_io_out;
    oeb     = s_oeb;
    inp_dis = s_inp_dis;
    hold    = s_hold;
    rise_en = s_rise;
    fall_en = s_fall;
    clr     = s_clr;
    tb_val  = s_ext;
    tb_en   = ~m_oe();
    e.io_in = m_in;
    e.pend  = m_pend;
    e.irq   = |m_pend;
    e.io    = m_bus();
    if (push) sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    if (resetb) model_edge();
    #1;
    resetb = 1'b1;
    apply(1'b1);
  endtask

  task automatic async_reset();
    @(posedge clock);
    model_edge();
    #3;
    resetb = 1'b0;
    model_reset();
    apply(1'b1);
  endtask

  task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        cmp("io_in", io_in, e.io_in);
        cmp("irq_pending", pend, e.pend);
        cmp("irq", N'(irq), N'(e.irq));
        cmp("io", io, e.io);
      end
    end
  end

  initial begin : stim
    model_reset();
    apply(1'b0);
    step();
    s_oeb = '0; s_io_out = 4'hA;
    repeat (2) step();
    s_hold = '1;
    step();
    s_io_out = 4'h5;
    repeat (3) step();
    s_hold = '0;
    step();
    s_oeb = '1; s_ext = 4'h3;
    repeat (SYNC + FILT + 2) step();
    s_ext = '0;
    repeat (SYNC + FILT + 2) step();
    s_clr = '1;
    step();
    s_clr = '0; s_rise = 4'h2; s_ext = 4'h2;
    repeat (SYNC + FILT + 2) step();
    s_ext = '0;
    repeat (SYNC + FILT + 2) step();
    s_clr = 4'h2;
    step();
    s_clr = '0; s_ext = 4'h2;
    for (int k = 0; k < 20 && !(m_in[1] & ~m_prev[1]); k++) step();
    #1;
    clr = 4'h2; s_clr = 4'h2;
    step();
    s_clr = '0;
    repeat (3) step();
    s_clr = 4'h2;
    step();
    s_clr = '0;
    repeat (2) step();
`ifdef MPRJ_IO_DEGLITCH_EN
    s_rise = '1; s_ext = '0;
    repeat (10) step();
    s_ext = 4'h1;
    repeat (3) step();
    s_ext = '0;
    repeat (10) step();
    s_ext = 4'h1;
    repeat (6) step();
    s_ext = '0;
    repeat (10) step();
`endif
    s_rise = '1; s_ext = '0;
    repeat (SYNC + FILT + 2) step();
    s_ext = '1;
    repeat (SYNC + FILT + 2) step();
    s_hold = '1; s_oeb = '0; s_io_out = 4'h9;
    step();
    async_reset();
    s_ext = 4'h6;
    repeat (4) step();
    s_hold = '0;
    for (int k = 0; k < 1500; k++) begin
      s_io_out  = N'($urandom);
      s_oeb     = N'($urandom);
      s_hold    = N'($urandom & $urandom);
      s_inp_dis = N'($urandom & $urandom & $urandom);
      s_rise    = N'($urandom);
      s_fall    = N'($urandom);
      s_clr     = N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) s_ext ^= N'($urandom);
      if ($urandom_range(0, 199) == 0) async_reset();
      else step();
    end
    @(negedge clock);
    #1;
    cmp("scoreboard_drained", N'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
